// File: rtl/lcd_pkg.sv
// Shared constants, message text and FSM encoding for the status LCD sequencer.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC  = 8'h38;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_0  = 8'h30;

    localparam int INIT_LEN  = 4;
    localparam int PAINT_LEN = 34;

    // Each message is exactly 16 characters, space padded, first character in the MSBs.
    localparam logic [127:0] MSG_PARADO   = "Parado          ";
    localparam logic [127:0] MSG_SUBINDO  = "Subindo ^       ";
    localparam logic [127:0] MSG_DESCENDO = "Descendo v      ";
    localparam logic [127:0] MSG_ERRO     = "Erro            ";
    localparam logic [127:0] MSG_ANDAR    = "Andar           ";

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT,
        S_DLY,
        S_NEXT,
        S_IDLE,
        S_SNAP
    } lcdState_t;

    function automatic logic [7:0] msgByte(input logic [127:0] msg, input logic [3:0] pos);
        return msg[8*(15 - int'(pos)) +: 8];
    endfunction

endpackage

// File: rtl/lcd_msg_rom.sv
// Combinational transfer table: init commands, or the two-line status/floor screen.
module lcd_msg_rom
    import lcd_pkg::*;
#(
    parameter int STATUS_W = 2,
    parameter int FLOOR_W  = 4
) (
    input  logic                initPhase,
    input  logic [STATUS_W-1:0] status,
    input  logic [FLOOR_W-1:0]  floor,
    input  logic [5:0]          idx,
    output logic [8:0]          xfer
);

    logic [5:0]   rem;
    logic [2:0]   tens;
    logic [127:0] line1;
    logic [7:0]   line2Char;
    logic [3:0]   pos1;
    logic [3:0]   pos2;

    // Floor is at most 63, so six conditional subtractions of ten are enough.
    always_comb begin
        rem  = 6'(floor);
        tens = '0;
        for (int k = 0; k < 6; k++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 3'd1;
            end
        end
    end

    always_comb begin
        case (int'(status))
            0:       line1 = MSG_PARADO;
            1:       line1 = MSG_SUBINDO;
            2:       line1 = MSG_DESCENDO;
            default: line1 = MSG_ERRO;
        endcase
    end

    assign pos1 = 4'(idx - 6'd1);
    assign pos2 = 4'(idx - 6'd18);

    always_comb begin
        line2Char = msgByte(MSG_ANDAR, pos2);
        if (pos2 == 4'd6 && tens != 3'd0) begin
            line2Char = ASC_0 + 8'(tens);
        end else if (pos2 == 4'd7) begin
            line2Char = ASC_0 + 8'(rem);
        end
    end

    always_comb begin
        xfer = {1'b0, CMD_FUNC};
        if (initPhase) begin
            case (idx[1:0])
                2'd0:    xfer = {1'b0, CMD_FUNC};
                2'd1:    xfer = {1'b0, CMD_DISP};
                2'd2:    xfer = {1'b0, CMD_CLR};
                default: xfer = {1'b0, CMD_ENTRY};
            endcase
        end else if (idx == 6'd0) begin
            xfer = {1'b0, CMD_LINE1};
        end else if (idx <= 6'd16) begin
            xfer = {1'b1, msgByte(line1, pos1)};
        end else if (idx == 6'd17) begin
            xfer = {1'b0, CMD_LINE2};
        end else begin
            xfer = {1'b1, line2Char};
        end
    end

endmodule

// File: rtl/lcd_status_display.sv
// Host-side HD44780 sequencer: one-time init, then repaints status and floor on change or refresh.
module lcd_status_display
    import lcd_pkg::*;
#(
    parameter int DLY_CYCLES = 262142,
    parameter int STATUS_W   = 2,
    parameter int FLOOR_W    = 4
) (
    input  logic                iCLK,
    input  logic                Reset,
    input  logic [STATUS_W-1:0] iStatus,
    input  logic [FLOOR_W-1:0]  iFloor,
    input  logic                iRefresh,
    input  logic                iDone,
    output logic [7:0]          oDATA,
    output logic                oRS,
    output logic                oStart,
    output logic                oBusy
);

    localparam int CNT_W = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES) : 1;

    lcdState_t           state;
    logic [5:0]          idx;
    logic                initDone;
    logic                pending;
    logic [CNT_W-1:0]    dlyCnt;
    logic [STATUS_W-1:0] snapStatus;
    logic [FLOOR_W-1:0]  snapFloor;
    logic [8:0]          romXfer;
    logic                inputsMoved;

    assign inputsMoved = (iStatus != snapStatus) || (iFloor != snapFloor);

    lcd_msg_rom #(
        .STATUS_W(STATUS_W),
        .FLOOR_W (FLOOR_W)
    ) uRom (
        .initPhase(!initDone),
        .status   (snapStatus),
        .floor    (snapFloor),
        .idx      (idx),
        .xfer     (romXfer)
    );

    always_ff @(posedge iCLK) begin
        if (Reset) begin
            state    <= S_LOAD;
            idx      <= '0;
            initDone <= 1'b0;
            pending  <= 1'b0;
            dlyCnt   <= '0;
            oDATA    <= '0;
            oRS      <= 1'b0;
            oStart   <= 1'b0;
            oBusy    <= 1'b1;
        end else begin
            // The snapshot is meaningless until the first paint, so input moves only queue after init.
            if ((state inside {S_LOAD, S_WAIT, S_DLY, S_NEXT}) &&
                (iRefresh || (initDone && inputsMoved))) begin
                pending <= 1'b1;
            end

            case (state)
                S_LOAD: begin
                    {oRS, oDATA} <= romXfer;
                    oStart       <= 1'b1;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (iDone) begin
                        oStart <= 1'b0;
                        dlyCnt <= '0;
                        state  <= S_DLY;
                    end
                end
                S_DLY: begin
                    if (dlyCnt == CNT_W'(DLY_CYCLES - 1)) begin
                        dlyCnt <= '0;
                        state  <= S_NEXT;
                    end else begin
                        dlyCnt <= dlyCnt + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (!initDone && idx == 6'(INIT_LEN - 1)) begin
                        initDone <= 1'b1;
                        state    <= S_SNAP;
                    end else if (initDone && idx == 6'(PAINT_LEN - 1)) begin
                        oBusy <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        idx   <= idx + 6'd1;
                        state <= S_LOAD;
                    end
                end
                S_IDLE: begin
                    if (pending || iRefresh || inputsMoved) begin
                        oBusy <= 1'b1;
                        state <= S_SNAP;
                    end
                end
                S_SNAP: begin
                    snapStatus <= iStatus;
                    snapFloor  <= iFloor;
                    pending    <= iRefresh;
                    idx        <= '0;
                    state      <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_status_display.sv
// Randomized bench: models the LCD_Controller handshake and predicts the transfer stream from screen text.
module tb_lcd_status_display;

    logic       iCLK = 1'b0;
    logic       Reset = 1'b1;
    logic [1:0] iStatus = '0;
    logic [3:0] iFloor = '0;
    logic       iRefresh = 1'b0;
    logic       iDone = 1'b0;
    logic [7:0] oDATA;
    logic       oRS;
    logic       oStart;
    logic       oBusy;

    int checks = 0;
    int errors = 0;

    logic [8:0] got[$];
    logic [8:0] exp[$];
    bit holdDone = 0;
    bit spuriousReq = 0;

    lcd_status_display #(
        .DLY_CYCLES(4),
        .STATUS_W  (2),
        .FLOOR_W   (4)
    ) dut (
        .iCLK    (iCLK),
        .Reset   (Reset),
        .iStatus (iStatus),
        .iFloor  (iFloor),
        .iRefresh(iRefresh),
        .iDone   (iDone),
        .oDATA   (oDATA),
        .oRS     (oRS),
        .oStart  (oStart),
        .oBusy   (oBusy)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkVal(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // LCD_Controller model: acknowledges a request 3 cycles after oStart and logs the byte.
    initial begin
        int cnt;
        bit ack;
        cnt = 0;
        ack = 0;
        forever begin
            @(negedge iCLK);
            iDone = 1'b0;
            if (Reset) begin
                cnt = 0;
                ack = 0;
            end else if (oStart && !ack) begin
                if (!holdDone) begin
                    cnt++;
                    if (cnt == 3) begin
                        iDone = 1'b1;
                        got.push_back({oRS, oDATA});
                        ack = 1;
                        cnt = 0;
                    end
                end
            end else if (!oStart) begin
                ack = 0;
                if (spuriousReq) begin
                    iDone = 1'b1;
                    spuriousReq = 0;
                end
            end
        end
    end

    task automatic addInit();
        exp.push_back(9'h038);
        exp.push_back(9'h00C);
        exp.push_back(9'h001);
        exp.push_back(9'h006);
    endtask

    task automatic addLine(input string s);
        for (int i = 0; i < 16; i++) begin
            if (i < s.len()) exp.push_back({1'b1, s[i]});
            else exp.push_back(9'h120);
        end
    endtask

    task automatic addPaint(input int st, input int fl);
        string l1;
        string l2;
        case (st)
            0: l1 = "Parado";
            1: l1 = "Subindo ^";
            2: l1 = "Descendo v";
            default: l1 = "Erro";
        endcase
        if (fl < 10) l2 = $sformatf("Andar  %0d", fl);
        else l2 = $sformatf("Andar %0d", fl);
        exp.push_back(9'h080);
        addLine(l1);
        exp.push_back(9'h0C0);
        addLine(l2);
    endtask

    task automatic compareXfers(input string tag);
        checkVal({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checkVal($sformatf("%s_x%0d", tag, i), got[i], exp[i]);
        end
        got.delete();
        exp.delete();
    endtask

    task automatic waitQuiet(input int budget);
        int quiet;
        int n;
        quiet = 0;
        n = 0;
        while (quiet < 8 && n < budget) begin
            @(negedge iCLK);
            n++;
            if (!oBusy && !oStart) quiet++;
            else quiet = 0;
        end
        checkVal("settle", quiet >= 8, 1);
    endtask

    task automatic waitXfers(input int need, input int budget);
        int n;
        n = 0;
        while (!(got.size() >= need && oStart) && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        checkVal("xfer_wait", (got.size() >= need) && oStart, 1);
    endtask

    task automatic pulseRefresh();
        iRefresh = 1'b1;
        @(negedge iCLK);
        iRefresh = 1'b0;
    endtask

    initial begin
        int fl;
        int fl3;
        int n;
        int changes;
        int curS;
        int curF;
        logic [7:0] d;
        logic r;
        int bnd[4];

        // Reset state and the boot sequence
        iStatus = 2'd0;
        iFloor  = 4'd3;
        Reset   = 1'b1;
        repeat (3) @(negedge iCLK);
        checkVal("rst_start", oStart, 0);
        checkVal("rst_busy", oBusy, 1);
        checkVal("rst_data", oDATA, 0);
        checkVal("rst_rs", oRS, 0);
        Reset = 1'b0;
        waitQuiet(4000);
        addInit();
        addPaint(0, 3);
        compareXfers("boot");

        // Input change in idle, with start latency
        iStatus = 2'd1;
        iFloor  = 4'd12;
        n = 0;
        while (!oStart && n < 20) begin
            @(negedge iCLK);
            n++;
        end
        checkVal("start_lat", n, 3);
        waitQuiet(4000);
        addPaint(1, 12);
        compareXfers("chg");

        // Floor change mid-paint: current paint finishes, one more follows
        iStatus = 2'd2;
        iFloor  = 4'd5;
        waitXfers(9, 2000);
        iFloor = 4'd7;
        waitQuiet(8000);
        addPaint(2, 5);
        addPaint(2, 7);
        compareXfers("tear");

        // Two refresh pulses during one paint queue a single repaint
        fl = (7 + 1 + $urandom_range(0, 14)) % 16;
        iFloor = 4'(fl);
        waitXfers(5, 2000);
        pulseRefresh();
        waitXfers(20, 2000);
        pulseRefresh();
        waitQuiet(8000);
        addPaint(2, fl);
        addPaint(2, fl);
        compareXfers("refr");

        // Stalled handshake holds outputs; a stray iDone in the delay is ignored
        holdDone = 1;
        pulseRefresh();
        n = 0;
        while (!oStart && n < 20) begin
            @(negedge iCLK);
            n++;
        end
        d = oDATA;
        r = oRS;
        checkVal("hold_first", {r, d}, 9'h080);
        changes = 0;
        repeat (100) begin
            @(negedge iCLK);
            if (oStart !== 1'b1 || oDATA !== d || oRS !== r) changes++;
        end
        checkVal("hold_stable", changes, 0);
        holdDone = 0;
        waitXfers(3, 2000);
        spuriousReq = 1;
        waitQuiet(4000);
        addPaint(2, fl);
        compareXfers("spur");

        // Reset in the middle of a paint restarts from init
        iFloor = 4'((fl + 1 + $urandom_range(0, 14)) % 16);
        waitXfers(15, 2000);
        Reset = 1'b1;
        fl3 = $urandom_range(0, 15);
        iStatus = 2'd3;
        iFloor  = 4'(fl3);
        @(negedge iCLK);
        checkVal("rst_drop", oStart, 0);
        checkVal("rst_busy2", oBusy, 1);
        @(negedge iCLK);
        Reset = 1'b0;
        got.delete();
        waitQuiet(4000);
        addInit();
        addPaint(3, fl3);
        compareXfers("rst_mid");
        curS = 3;
        curF = fl3;

        // Floor boundaries and random status/floor updates
        bnd[0] = 9;
        bnd[1] = 10;
        bnd[2] = 0;
        bnd[3] = 15;
        for (int k = 0; k < 8; k++) begin
            int s;
            int f;
            s = $urandom_range(0, 3);
            f = (k < 4) ? bnd[k] : $urandom_range(0, 15);
            iStatus = 2'(s);
            iFloor  = 4'(f);
            waitQuiet(4000);
            if (s != curS || f != curF) addPaint(s, f);
            compareXfers($sformatf("rnd%0d", k));
            curS = s;
            curF = f;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
